aes_dec_round_ctrl: RTL and testbench

Iterative AES inverse-cipher engine controller. It accepts one 128-bit ciphertext block per transaction and applies the inverse rounds one per clock on an internal state register. It fetches round keys from the expanded-key store, then returns the plaintext over a valid/ready handshake. It sits between the bus-side block buffer and the expanded-key RAM/ROM, and it owns the sequencing of the inverse shift-rows, inverse sub-bytes, add-round-key and inverse mix-columns functions.

---
 rtl/aes_pkg.sv | 39 +++
 rtl/aes_dec_round_ctrl_if.sv | 12 +
 rtl/aes_inv_round.sv | 19 +
 rtl/aes_dec_round_ctrl.sv | 81 ++++++++
 tb/tb_aes_dec_round_ctrl.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES inverse-cipher types, FSM states and GF(2^8) helpers
package aes_pkg;
  localparam int NR_128 = 10;
  localparam int NR_192 = 12;
  localparam int NR_256 = 14;
  typedef logic [127:0] block_t;
  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;
  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};
  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[b];
  endfunction
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  // multiply by a 4-bit constant, enough for the inverse mix-columns coefficients
  function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] m);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return ({8{m[0]}} & b) ^ ({8{m[1]}} & x2) ^ ({8{m[2]}} & x4) ^ ({8{m[3]}} & x8);
  endfunction
  function automatic logic [31:0] inv_mix_col(input logic [31:0] a);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = a;
    return {gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9),
            gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd),
            gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb),
            gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he)};
  endfunction
endpackage

// File: rtl/aes_dec_round_ctrl_if.sv
// aes_dec_round_ctrl_if: ciphertext-in / plaintext-out valid-ready bus
interface aes_dec_round_ctrl_if;
  import aes_pkg::*;
  logic   in_valid;
  logic   in_ready;
  block_t in_data;
  logic   out_valid;
  logic   out_ready;
  block_t out_data;
  modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data);
  modport slave  (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/aes_inv_round.sv
// aes_inv_round: one combinational inverse round, mix-columns skipped on the last round
module aes_inv_round
  import aes_pkg::*;
(
  input  block_t i_state,
  input  block_t i_rk,
  input  logic   i_last,
  output block_t o_state
);
  block_t w_sb, w_ark, w_mc;
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign w_sb[127-8*(4*c+r) -: 8] = inv_sbox(i_state[127-8*(4*((c+4-r)%4)+r) -: 8]);
    end
    assign w_mc[127-32*c -: 32] = inv_mix_col(w_ark[127-32*c -: 32]);
  end
  assign w_ark   = w_sb ^ i_rk;
  assign o_state = i_last ? w_ark : w_mc;
endmodule

// File: rtl/aes_dec_round_ctrl.sv
// aes_dec_round_ctrl: iterative AES inverse cipher, one round per clock
module aes_dec_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR    = NR_128,
  parameter int RK_AW = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  aes_dec_round_ctrl_if.slave bus,
  input  logic               i_key_ready,
  output logic [RK_AW-1:0]   o_rk_addr,
  input  block_t             i_rk_data,
  output logic               o_busy,
  output logic [RK_AW-1:0]   o_round
);
  localparam logic [RK_AW-1:0] RND_INIT  = RK_AW'(NR);
  localparam logic [RK_AW-1:0] RND_FIRST = RK_AW'(NR - 1);
  localparam logic [RK_AW-1:0] RND_ONE   = RK_AW'(1);
  if (NR != NR_128 && NR != NR_192 && NR != NR_256) begin : g_bad_nr
    $error("aes_dec_round_ctrl: NR must be 10, 12 or 14");
  end
  if ((1 << RK_AW) <= NR) begin : g_bad_aw
    $error("aes_dec_round_ctrl: RK_AW too narrow for NR");
  end
  state_t           r_state, w_state_nxt;
  logic [RK_AW-1:0] r_rnd, w_rnd_nxt;
  block_t           r_blk, w_blk_nxt, w_round_out;
  logic             w_accept;
  aes_inv_round u_round (
    .i_state (r_blk),
    .i_rk    (i_rk_data),
    .i_last  (r_state == FINAL),
    .o_state (w_round_out)
  );
  assign bus.in_ready  = rst_n && (r_state == IDLE) && i_key_ready;
  assign w_accept      = bus.in_valid && bus.in_ready;
  assign bus.out_valid = (r_state == DONE);
  assign bus.out_data  = r_blk;
  assign o_busy        = (r_state != IDLE);
  assign o_rk_addr     = r_rnd;
  assign o_round       = r_rnd;
  // next state, round counter and block: initial key add, middle rounds, final round, hand-off
  always_comb begin
    w_state_nxt = r_state;
    w_rnd_nxt   = r_rnd;
    w_blk_nxt   = r_blk;
    case (r_state)
      IDLE: if (w_accept) begin
        w_blk_nxt   = bus.in_data ^ i_rk_data;
        w_rnd_nxt   = RND_FIRST;
        w_state_nxt = (NR == 1) ? FINAL : ROUND;
      end
      ROUND: begin
        w_blk_nxt   = w_round_out;
        w_rnd_nxt   = r_rnd - RND_ONE;
        w_state_nxt = (r_rnd == RND_ONE) ? FINAL : ROUND;
      end
      FINAL: begin
        w_blk_nxt   = w_round_out;
        w_state_nxt = DONE;
      end
      DONE: if (bus.out_ready) begin
        w_rnd_nxt   = RND_INIT;
        w_state_nxt = IDLE;
      end
    endcase
  end
  // state, counter and block registers; reset discards any partial result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_rnd   <= RND_INIT;
      r_blk   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_rnd   <= w_rnd_nxt;
      r_blk   <= w_blk_nxt;
    end
  end
endmodule

// File: tb/tb_aes_dec_round_ctrl.sv
// tb_aes_dec_round_ctrl: scoreboard bench against FIPS-197 known-answer vectors
module tb_aes_dec_round_ctrl;
  import aes_pkg::*;
  localparam int NR   = 10;
  localparam int NR14 = 14;
  localparam int AW   = 4;
  localparam block_t K128 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam block_t C1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam block_t PT   = 128'h00112233445566778899aabbccddeeff;
  localparam block_t KB   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam block_t CB   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam block_t PB   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam block_t C3   = 128'h8ea2b7ca516745bfeafc49904b496089;
  logic clk = 0, rst_n = 0, key_ready = 1, key_ready14 = 1;
  logic [AW-1:0] rk_addr, round, rk_addr14, round14;
  logic busy, busy14;
  block_t rk10 [16];
  block_t rk14 [16];
  logic [31:0] kw [60];
  logic [7:0] sbox [256];
  block_t exp_q [$];
  int n_chk = 0, n_err = 0;
  int w, lat;
  logic seen;
  aes_dec_round_ctrl_if bus ();
  aes_dec_round_ctrl_if bus14 ();
  aes_dec_round_ctrl #(.NR(NR), .RK_AW(AW)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .i_key_ready(key_ready),
    .o_rk_addr(rk_addr), .i_rk_data(rk10[rk_addr]), .o_busy(busy), .o_round(round));
  aes_dec_round_ctrl #(.NR(NR14), .RK_AW(AW)) u_dut14 (
    .clk(clk), .rst_n(rst_n), .bus(bus14), .i_key_ready(key_ready14),
    .o_rk_addr(rk_addr14), .i_rk_data(rk14[rk_addr14]), .o_busy(busy14), .o_round(round14));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox[x[31:24]], sbox[x[23:16]], sbox[x[15:8]], sbox[x[7:0]]};
  endfunction
  function automatic logic [7:0] rcon(input int j);
    logic [7:0] r = 8'h01;
    for (int i = 1; i < j; i++) r = xtime(r);
    return r;
  endfunction
  task automatic expand(input logic [255:0] key, input int nk, input int nr);
    logic [31:0] t;
    for (int i = 0; i < nk; i++) kw[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = kw[i-1];
      if (i % nk == 0) t = sub_word({t[23:0], t[31:24]}) ^ {rcon(i / nk), 24'h0};
      else if (nk > 6 && i % nk == 4) t = sub_word(t);
      kw[i] = kw[i-nk] ^ t;
    end
  endtask
  task automatic load10(input block_t key);
    expand({key, 128'h0}, 4, NR);
    for (int k = 0; k <= NR; k++) rk10[k] = {kw[4*k], kw[4*k+1], kw[4*k+2], kw[4*k+3]};
  endtask
  // one transaction on the NR=10 engine: accept, trace rk_addr, optional backpressure, drain
  task automatic xact(input block_t ct, input block_t exp, input int hold, input bit keep, output int waits);
    int l;
    bus.in_valid = 1;
    bus.in_data  = ct;
    waits = 0;
    #1;
    while (!bus.in_ready && waits < 50) begin
      @(negedge clk);
      #1;
      waits++;
    end
    chk("accept", 128'(bus.in_ready), 128'(1));
    exp_q.push_back(exp);
    l = 0;
    do begin
      chk("rk_addr", 128'(rk_addr), 128'(NR - l));
      @(negedge clk);
      bus.in_valid = keep;
      #1;
      l++;
    end while (!bus.out_valid && l < 40);
    chk("latency", 128'(l), 128'(NR + 1));
    repeat (hold) begin
      chk("hold_data", bus.out_data, exp_q[0]);
      chk("hold_in_ready", 128'(bus.in_ready), 128'(0));
      chk("hold_valid", 128'(bus.out_valid), 128'(1));
      @(negedge clk);
      #1;
    end
    bus.out_ready = 1;
    chk("out_valid", 128'(bus.out_valid), 128'(1));
    chk("out_data", bus.out_data, exp_q.pop_front());
    @(negedge clk);
    bus.out_ready = 0;
    #1;
    chk("drop_valid", 128'(bus.out_valid), 128'(0));
    chk("rk_rewind", 128'(rk_addr), 128'(NR));
    chk("idle_ready", 128'(bus.in_ready), 128'(1));
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < 256; i++) sbox[inv_sbox(8'(i))] = 8'(i);
    for (int k = 0; k < 16; k++) begin
      rk10[k] = '0;
      rk14[k] = '0;
    end
    load10(K128);
    expand(K256, 8, NR14);
    for (int k = 0; k <= NR14; k++) rk14[k] = {kw[4*k], kw[4*k+1], kw[4*k+2], kw[4*k+3]};
    bus.in_valid = 0; bus.in_data = '0; bus.out_ready = 0;
    bus14.in_valid = 0; bus14.in_data = '0; bus14.out_ready = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_in_ready", 128'(bus.in_ready), 128'(0));
    chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_rk_addr", 128'(rk_addr), 128'(NR));
    chk("rst_round", 128'(round), 128'(NR));
    chk("rst_rk_addr14", 128'(rk_addr14), 128'(NR14));
    @(negedge clk);
    rst_n = 1;
    #1;
    chk("rel_in_ready", 128'(bus.in_ready), 128'(1));
    xact(C1, PT, 20, 0, w);
    key_ready = 0;
    bus.in_valid = 1;
    bus.in_data = C1;
    repeat (4) begin
      @(negedge clk);
      #1;
      chk("kr_in_ready", 128'(bus.in_ready), 128'(0));
      chk("kr_busy", 128'(busy), 128'(0));
    end
    key_ready = 1;
    #1;
    chk("kr_raise", 128'(bus.in_ready), 128'(1));
    xact(C1, PT, 0, 1, w);
    chk("kr_wait", 128'(w), 128'(0));
    xact(C1, PT, 0, 0, w);
    chk("b2b_wait", 128'(w), 128'(0));
    load10(KB);
    xact(CB, PB, 0, 0, w);
    load10(K128);
    bus.in_valid = 1;
    bus.in_data = C1;
    #1;
    chk("mid_accept", 128'(bus.in_ready), 128'(1));
    @(negedge clk);
    bus.in_valid = 0;
    repeat (4) @(negedge clk);
    rst_n = 0;
    #1;
    chk("mid_busy", 128'(busy), 128'(0));
    chk("mid_rk_addr", 128'(rk_addr), 128'(NR));
    chk("mid_out_valid", 128'(bus.out_valid), 128'(0));
    @(negedge clk);
    rst_n = 1;
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      #1;
      seen |= bus.out_valid;
    end
    chk("mid_no_output", 128'(seen), 128'(0));
    xact(C1, PT, 0, 0, w);
    bus14.in_valid = 1;
    bus14.in_data = C3;
    #1;
    chk("a14_ready", 128'(bus14.in_ready), 128'(1));
    lat = 0;
    do begin
      @(negedge clk);
      bus14.in_valid = 0;
      #1;
      lat++;
    end while (!bus14.out_valid && lat < 40);
    chk("a14_latency", 128'(lat), 128'(NR14 + 1));
    bus14.out_ready = 1;
    chk("a14_out_data", bus14.out_data, PT);
    @(negedge clk);
    bus14.out_ready = 0;
    #1;
    chk("a14_drop", 128'(bus14.out_valid), 128'(0));
    chk("a14_busy", 128'(busy14), 128'(0));
    chk("a14_rk_rewind", 128'(rk_addr14), 128'(NR14));
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
